// File: rtl/neuro_pkg.sv
// Shared constants, types and sweep state encoding for the neuron state
// register (NSR) fire sweeper.
package neuro_pkg;

    localparam int NUM_NEURONS = 32;
    localparam int DATA_W      = 32;
    localparam int IDX_W       = 5;

    typedef logic [IDX_W-1:0]         nsr_idx_t;
    typedef logic signed [DATA_W-1:0] membrane_t;

    typedef enum logic [1:0] {
        IDLE,
        READ,
        UPDATE,
        DONE
    } sweep_state_e;

endpackage

// File: rtl/lif_update.sv
// Leaky-integrate-and-fire step for one neuron: leak by arithmetic shift,
// compare against threshold, reset to zero on fire.
module lif_update #(
    parameter int DATA_W = neuro_pkg::DATA_W
) (
    input  logic signed [DATA_W-1:0] v_i,
    input  logic        [4:0]        leak_shift_i,
    input  logic signed [DATA_W-1:0] threshold_i,
    output logic signed [DATA_W-1:0] new_v_o,
    output logic                     fire_o
);

    logic signed [DATA_W-1:0] vl;

    // v - (v >>> s) moves v toward zero, so it can never overflow
    assign vl      = (leak_shift_i == 5'd0) ? v_i : (v_i - (v_i >>> leak_shift_i));
    assign fire_o  = (vl >= threshold_i);
    assign new_v_o = fire_o ? '0 : vl;

endmodule

// File: rtl/nsr_fire_sweeper.sv
// Walks the NSR after accumulation, applying leak/threshold to each neuron and
// collecting spike bits; yields the shared NSR ports to the pipeline.
module nsr_fire_sweeper #(
    parameter int NUM_NEURONS = neuro_pkg::NUM_NEURONS,
    parameter int DATA_W      = neuro_pkg::DATA_W,
    parameter int IDX_W       = neuro_pkg::IDX_W
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic [IDX_W:0]           num_neurons,
    input  logic signed [DATA_W-1:0] threshold,
    input  logic [4:0]               leak_shift,
    input  logic                     pipe_nsr_we,
    input  logic [IDX_W-1:0]         pipe_nsr_wa,
    output logic [IDX_W-1:0]         nsr_ra,
    input  logic signed [DATA_W-1:0] nsr_rd,
    output logic                     nsr_we,
    output logic [IDX_W-1:0]         nsr_wa,
    output logic signed [DATA_W-1:0] nsr_wd,
    output logic                     busy,
    output logic                     done,
    output logic [NUM_NEURONS-1:0]   spike_vec,
    output logic [IDX_W:0]           spike_count
);

    import neuro_pkg::*;

    localparam int              CNT_W   = IDX_W + 1;
    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(NUM_NEURONS);

    sweep_state_e             state_q, state_d;
    logic [IDX_W-1:0]         idx_q, idx_d;
    logic [CNT_W-1:0]         count_q, count_d;
    logic signed [DATA_W-1:0] thr_q, thr_d;
    logic [4:0]               shift_q, shift_d;
    logic signed [DATA_W-1:0] v_q, v_d;
    logic [NUM_NEURONS-1:0]   spike_vec_q, spike_vec_d;
    logic [CNT_W-1:0]         spike_cnt_q, spike_cnt_d;

    logic signed [DATA_W-1:0] new_v;
    logic                     fire;
    logic [CNT_W-1:0]         start_cnt;
    logic                     last_idx;
    logic                     stale;

    assign start_cnt = (num_neurons > MAX_CNT) ? MAX_CNT : num_neurons;
    assign last_idx  = ({1'b0, idx_q} == (count_q - CNT_W'(1)));
    // A pipeline write to the neuron we hold invalidates the sampled value
    assign stale     = pipe_nsr_we && (pipe_nsr_wa == idx_q);

    lif_update #(
        .DATA_W(DATA_W)
    ) u_lif (
        .v_i          (v_q),
        .leak_shift_i (shift_q),
        .threshold_i  (thr_q),
        .new_v_o      (new_v),
        .fire_o       (fire)
    );

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        count_d     = count_q;
        thr_d       = thr_q;
        shift_d     = shift_q;
        v_d         = v_q;
        spike_vec_d = spike_vec_q;
        spike_cnt_d = spike_cnt_q;
        nsr_we      = 1'b0;
        nsr_wa      = '0;
        nsr_wd      = '0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    count_d     = start_cnt;
                    thr_d       = threshold;
                    shift_d     = leak_shift;
                    spike_vec_d = '0;
                    spike_cnt_d = '0;
                    idx_d       = '0;
                    state_d     = (start_cnt == '0) ? DONE : READ;
                end
            end
            READ: begin
                if (!pipe_nsr_we) begin
                    v_d     = nsr_rd;
                    state_d = UPDATE;
                end
            end
            UPDATE: begin
                if (stale) begin
                    state_d = READ;
                end else if (!pipe_nsr_we) begin
                    nsr_we = 1'b1;
                    nsr_wa = idx_q;
                    nsr_wd = new_v;
                    if (fire) begin
                        spike_vec_d[idx_q] = 1'b1;
                        spike_cnt_d        = spike_cnt_q + CNT_W'(1);
                    end
                    if (last_idx) begin
                        state_d = DONE;
                    end else begin
                        idx_d   = idx_q + IDX_W'(1);
                        state_d = READ;
                    end
                end
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            count_q     <= '0;
            thr_q       <= '0;
            shift_q     <= '0;
            v_q         <= '0;
            spike_vec_q <= '0;
            spike_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            count_q     <= count_d;
            thr_q       <= thr_d;
            shift_q     <= shift_d;
            v_q         <= v_d;
            spike_vec_q <= spike_vec_d;
            spike_cnt_q <= spike_cnt_d;
        end
    end

    assign nsr_ra      = idx_q;
    assign busy        = (state_q != IDLE);
    assign done        = (state_q == DONE);
    assign spike_vec   = spike_vec_q;
    assign spike_count = spike_cnt_q;

endmodule

// File: tb/tb_nsr_fire_sweeper.sv
// Bench for nsr_fire_sweeper: NSR memory model, scripted and random pipeline
// traffic, and a per-write LIF reference check.
module tb_nsr_fire_sweeper;

    localparam int N = 32;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic               reset, start, pipe_nsr_we, load_req;
    logic [5:0]         num_neurons, spike_count;
    logic signed [31:0] threshold, pipe_wd, nsr_rd, nsr_wd;
    logic [4:0]         leak_shift, pipe_nsr_wa, nsr_ra, nsr_wa;
    logic               nsr_we, busy, done;
    logic [N-1:0]       spike_vec;

    logic signed [31:0] mem [N];
    logic signed [31:0] init_mem [N];

    int                 cyc, done_cnt, done_cyc, overlap;
    int                 wr_addr [$];
    int                 wr_cyc [$];
    logic signed [31:0] wr_data [$];
    logic signed [31:0] wr_old [$];
    int                 n_checks, n_pass;

    nsr_fire_sweeper dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .num_neurons (num_neurons),
        .threshold   (threshold),
        .leak_shift  (leak_shift),
        .pipe_nsr_we (pipe_nsr_we),
        .pipe_nsr_wa (pipe_nsr_wa),
        .nsr_ra      (nsr_ra),
        .nsr_rd      (nsr_rd),
        .nsr_we      (nsr_we),
        .nsr_wa      (nsr_wa),
        .nsr_wd      (nsr_wd),
        .busy        (busy),
        .done        (done),
        .spike_vec   (spike_vec),
        .spike_count (spike_count)
    );

    assign nsr_rd = mem[nsr_ra];

    always @(posedge clk) begin
        if (load_req) begin
            for (int i = 0; i < N; i++) mem[i] <= init_mem[i];
        end else begin
            if (pipe_nsr_we) mem[pipe_nsr_wa] <= pipe_wd;
            if (nsr_we) mem[nsr_wa] <= nsr_wd;
        end
    end

    // Event recorder: sampled mid-cycle, mem still holds pre-write contents
    always @(negedge clk) begin
        cyc = cyc + 1;
        if (nsr_we) begin
            wr_addr.push_back(int'(nsr_wa));
            wr_data.push_back(nsr_wd);
            wr_old.push_back(mem[nsr_wa]);
            wr_cyc.push_back(cyc);
        end
        if (nsr_we && pipe_nsr_we) overlap = overlap + 1;
        if (done) begin
            done_cnt = done_cnt + 1;
            done_cyc = cyc;
        end
    end

    // Reference: leak is v minus floor(v / 2^s)
    function automatic longint exp_vl(input longint v, input int s);
        longint p, q;
        if (s == 0) return v;
        p = longint'(1) << s;
        q = v / p;
        if (v < 0 && (v % p) != 0) q = q - 1;
        return v - q;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_mem();
        load_req = 1'b1;
        tick();
        load_req = 1'b0;
    endtask

    task automatic run_sweep(input int nn, input int thr, input int ls,
                             input int pw_from, input int pw_to, input int pw_addr,
                             input int pw_data, input bit rnd_pipe, input int restart_rel,
                             output int t, output int base, output bit timed_out);
        int d0, rel;
        base        = wr_addr.size();
        d0          = done_cnt;
        num_neurons = 6'(nn);
        threshold   = 32'(thr);
        leak_shift  = 5'(ls);
        start       = 1'b1;
        t           = cyc + 1;
        tick();
        start     = 1'b0;
        timed_out = 1'b1;
        for (int k = 0; k < 1000; k++) begin
            if (done_cnt != d0) begin
                timed_out = 1'b0;
                break;
            end
            rel = cyc + 1 - t;
            if (rnd_pipe) begin
                pipe_nsr_we = ($urandom_range(0, 2) == 0);
                pipe_nsr_wa = ($urandom_range(0, 1) == 1) ? nsr_ra : 5'($urandom_range(0, 31));
                pipe_wd     = $urandom;
            end else begin
                pipe_nsr_we = (rel >= pw_from) && (rel <= pw_to);
                pipe_nsr_wa = 5'(pw_addr);
                pipe_wd     = 32'(pw_data);
            end
            start = (rel == restart_rel);
            if (start) begin
                num_neurons = 6'd1;
                threshold   = -32'sd1000;
            end
            tick();
        end
        pipe_nsr_we = 1'b0;
        start       = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        n_checks++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else n_pass++;
        n_checks++; if (done !== 1'b0) $display("FAIL reset_done: got %b want 0", done); else n_pass++;
        n_checks++; if (nsr_we !== 1'b0) $display("FAIL reset_we: got %b want 0", nsr_we); else n_pass++;
        n_checks++; if (nsr_ra !== 5'd0) $display("FAIL reset_ra: got %0d want 0", nsr_ra); else n_pass++;
        n_checks++; if (nsr_wa !== 5'd0 || nsr_wd !== 32'sd0) $display("FAIL reset_wa_wd: got %0d/%0d want 0/0", nsr_wa, nsr_wd); else n_pass++;
        n_checks++; if (spike_vec !== '0 || spike_count !== 6'd0) $display("FAIL reset_spikes: got %h/%0d want 0/0", spike_vec, spike_count); else n_pass++;
        reset = 1'b0;
        tick();
    endtask

    task automatic test_basic();
        int  exp_d [4] = '{0, 99, 0, -5};
        int  t, base;
        bit  to;
        init_mem[0] = 150; init_mem[1] = 99; init_mem[2] = 100; init_mem[3] = -5;
        load_mem();
        run_sweep(4, 100, 0, -1, -1, 0, 0, 1'b0, -1, t, base, to);
        n_checks++; if (to) $display("FAIL basic_timeout: done never seen"); else n_pass++;
        n_checks++; if (done_cyc != t + 9) $display("FAIL basic_done_cycle: got %0d want %0d", done_cyc - t, 9); else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("FAIL basic_idle_after: busy %b want 0", busy); else n_pass++;
        n_checks++; if (wr_addr.size() - base != 4) $display("FAIL basic_nwrites: got %0d want 4", wr_addr.size() - base); else n_pass++;
        for (int k = 0; k < 4 && base + k < wr_addr.size(); k++) begin
            n_checks++;
            if (wr_addr[base+k] != k || wr_data[base+k] !== 32'(exp_d[k]) || wr_cyc[base+k] != t + 2 + 2*k)
                $display("FAIL basic_write[%0d]: got a=%0d d=%0d c=%0d want a=%0d d=%0d c=%0d",
                         k, wr_addr[base+k], wr_data[base+k], wr_cyc[base+k] - t, k, exp_d[k], 2 + 2*k);
            else n_pass++;
        end
        n_checks++; if (spike_vec !== 32'h5) $display("FAIL basic_spike_vec: got %h want 00000005", spike_vec); else n_pass++;
        n_checks++; if (spike_count !== 6'd2) $display("FAIL basic_spike_count: got %0d want 2", spike_count); else n_pass++;
        n_checks++; if (mem[2] !== 32'sd0 || mem[3] !== -32'sd5) $display("FAIL basic_mem: got %0d,%0d want 0,-5", mem[2], mem[3]); else n_pass++;
    endtask

    task automatic test_leak();
        int t, base;
        bit to;
        init_mem[0] = 80;
        load_mem();
        run_sweep(1, 60, 2, -1, -1, 0, 0, 1'b0, -1, t, base, to);
        n_checks++; if (to || done_cyc != t + 3) $display("FAIL leak80_done: got %0d want 3", done_cyc - t); else n_pass++;
        n_checks++; if (wr_data.size() <= base || wr_data[base] !== 32'sd0) $display("FAIL leak80_write: got %0d want 0", mem[0]); else n_pass++;
        n_checks++; if (spike_vec !== 32'h1 || spike_count !== 6'd1) $display("FAIL leak80_spikes: got %h/%0d want 1/1", spike_vec, spike_count); else n_pass++;
        init_mem[0] = 76;
        load_mem();
        run_sweep(1, 60, 2, -1, -1, 0, 0, 1'b0, -1, t, base, to);
        n_checks++; if (wr_data.size() <= base || wr_data[base] !== 32'sd57) $display("FAIL leak76_write: got %0d want 57", mem[0]); else n_pass++;
        n_checks++; if (spike_vec !== 32'h0 || spike_count !== 6'd0) $display("FAIL leak76_spikes: got %h/%0d want 0/0", spike_vec, spike_count); else n_pass++;
    endtask

    task automatic test_contention();
        int t, base, ov0;
        bit to;
        for (int i = 0; i < 4; i++) init_mem[i] = i + 1;
        load_mem();
        ov0 = overlap;
        run_sweep(4, 100, 0, 5, 7, 7, 1234, 1'b0, -1, t, base, to);
        n_checks++; if (to || done_cyc != t + 12) $display("FAIL cont_done: got %0d want 12", done_cyc - t); else n_pass++;
        n_checks++; if (overlap != ov0) $display("FAIL cont_overlap: got %0d want 0", overlap - ov0); else n_pass++;
        n_checks++;
        if (wr_addr.size() - base != 4 || wr_cyc[base+2] != t + 9 || wr_data[base+2] !== 32'sd3)
            $display("FAIL cont_write2: got n=%0d c=%0d want n=4 c=9 d=3", wr_addr.size() - base, wr_cyc[base+2] - t);
        else n_pass++;
        n_checks++; if (mem[7] !== 32'sd1234) $display("FAIL cont_pipe_mem: got %0d want 1234", mem[7]); else n_pass++;
    endtask

    task automatic test_stale();
        int exp_d [4] = '{10, 20, 0, 40};
        int t, base;
        bit to;
        for (int i = 0; i < 4; i++) init_mem[i] = 10 * (i + 1);
        load_mem();
        run_sweep(4, 100, 0, 6, 6, 2, 500, 1'b0, -1, t, base, to);
        n_checks++; if (to || done_cyc != t + 11) $display("FAIL stale_done: got %0d want 11", done_cyc - t); else n_pass++;
        n_checks++; if (wr_addr.size() - base != 4) $display("FAIL stale_nwrites: got %0d want 4", wr_addr.size() - base); else n_pass++;
        for (int k = 0; k < 4 && base + k < wr_addr.size(); k++) begin
            n_checks++;
            if (wr_addr[base+k] != k || wr_data[base+k] !== 32'(exp_d[k]))
                $display("FAIL stale_write[%0d]: got a=%0d d=%0d want a=%0d d=%0d", k, wr_addr[base+k], wr_data[base+k], k, exp_d[k]);
            else n_pass++;
        end
        n_checks++; if (spike_vec !== 32'h4 || spike_count !== 6'd1) $display("FAIL stale_spikes: got %h/%0d want 4/1", spike_vec, spike_count); else n_pass++;
    endtask

    task automatic test_restart_and_zero();
        int t, base;
        bit to;
        init_mem[0] = 150; init_mem[1] = 99; init_mem[2] = 100; init_mem[3] = -5;
        load_mem();
        run_sweep(4, 100, 0, -1, -1, 0, 0, 1'b0, 3, t, base, to);
        n_checks++; if (to || wr_addr.size() - base != 4) $display("FAIL restart_nwrites: got %0d want 4", wr_addr.size() - base); else n_pass++;
        n_checks++; if (spike_vec !== 32'h5 || spike_count !== 6'd2) $display("FAIL restart_spikes: got %h/%0d want 5/2", spike_vec, spike_count); else n_pass++;
        run_sweep(0, 100, 0, -1, -1, 0, 0, 1'b0, -1, t, base, to);
        n_checks++; if (to || done_cyc != t + 1) $display("FAIL zero_done: got %0d want 1", done_cyc - t); else n_pass++;
        n_checks++; if (wr_addr.size() != base) $display("FAIL zero_writes: got %0d want 0", wr_addr.size() - base); else n_pass++;
        n_checks++; if (spike_vec !== '0 || spike_count !== 6'd0) $display("FAIL zero_spikes: got %h/%0d want 0/0", spike_vec, spike_count); else n_pass++;
    endtask

    task automatic test_reset_mid();
        int t, base;
        for (int i = 0; i < 4; i++) init_mem[i] = 200;
        load_mem();
        num_neurons = 6'd4;
        threshold   = 32'sd100;
        leak_shift  = 5'd0;
        start       = 1'b1;
        t           = cyc + 1;
        tick();
        start = 1'b0;
        while (cyc + 1 < t + 4) tick();
        n_checks++; if (nsr_we !== 1'b1 || nsr_wa !== 5'd1) $display("FAIL rmid_in_update1: got we=%b wa=%0d want 1/1", nsr_we, nsr_wa); else n_pass++;
        reset = 1'b1;
        tick();
        n_checks++; if (busy !== 1'b0 || done !== 1'b0) $display("FAIL rmid_idle: got busy=%b done=%b want 0/0", busy, done); else n_pass++;
        n_checks++; if (spike_vec !== '0 || spike_count !== 6'd0) $display("FAIL rmid_spikes: got %h/%0d want 0/0", spike_vec, spike_count); else n_pass++;
        reset = 1'b0;
        base  = wr_addr.size();
        repeat (10) tick();
        n_checks++; if (wr_addr.size() != base || busy !== 1'b0) $display("FAIL rmid_no_writes: got %0d writes busy=%b want 0/0", wr_addr.size() - base, busy); else n_pass++;
    endtask

    task automatic test_random();
        int           t, base, nn, thr, ls, ov0, n_exp, pop;
        bit           to;
        logic [N-1:0] exp_vec;
        longint       vl;
        logic signed [31:0] exp_w;
        for (int it = 0; it < 6; it++) begin
            for (int i = 0; i < N; i++)
                init_mem[i] = ($urandom_range(0, 1) == 1) ? $urandom : int'($urandom_range(0, 2000)) - 1000;
            load_mem();
            nn    = (it == 0) ? 40 : int'($urandom_range(1, 32));
            thr   = int'($urandom_range(0, 1000)) - 300;
            ls    = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 31)) : int'($urandom_range(0, 4));
            n_exp = (nn > N) ? N : nn;
            ov0   = overlap;
            run_sweep(nn, thr, ls, -1, -1, 0, 0, 1'b1, -1, t, base, to);
            n_checks++; if (to) $display("FAIL rnd%0d_timeout: done never seen", it); else n_pass++;
            n_checks++; if (wr_addr.size() - base != n_exp) $display("FAIL rnd%0d_nwrites: got %0d want %0d", it, wr_addr.size() - base, n_exp); else n_pass++;
            n_checks++; if (overlap != ov0) $display("FAIL rnd%0d_overlap: got %0d want 0", it, overlap - ov0); else n_pass++;
            exp_vec = '0;
            pop     = 0;
            for (int k = 0; k < n_exp && base + k < wr_addr.size(); k++) begin
                vl    = exp_vl(longint'(wr_old[base+k]), ls);
                exp_w = (vl >= thr) ? 32'sd0 : 32'(vl);
                if (vl >= thr) begin
                    exp_vec[k] = 1'b1;
                    pop++;
                end
                n_checks++;
                if (wr_addr[base+k] != k || wr_data[base+k] !== exp_w)
                    $display("FAIL rnd%0d_write[%0d]: got a=%0d d=%0d want a=%0d d=%0d (v=%0d s=%0d th=%0d)",
                             it, k, wr_addr[base+k], wr_data[base+k], k, exp_w, wr_old[base+k], ls, thr);
                else n_pass++;
            end
            n_checks++; if (spike_vec !== exp_vec) $display("FAIL rnd%0d_spike_vec: got %h want %h", it, spike_vec, exp_vec); else n_pass++;
            n_checks++; if (spike_count !== 6'(pop)) $display("FAIL rnd%0d_spike_count: got %0d want %0d", it, spike_count, pop); else n_pass++;
        end
    endtask

    initial begin
        reset       = 1'b1;
        start       = 1'b0;
        load_req    = 1'b0;
        num_neurons = 6'd0;
        threshold   = 32'sd0;
        leak_shift  = 5'd0;
        pipe_nsr_we = 1'b0;
        pipe_nsr_wa = 5'd0;
        pipe_wd     = 32'sd0;
        for (int i = 0; i < N; i++) init_mem[i] = 0;
        test_reset();
        load_mem();
        test_basic();
        test_leak();
        test_contention();
        test_stale();
        test_restart_and_zero();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/nsr_fire_sweeper.md
Name: nsr_fire_sweeper

Overview:
Sequencer that runs a leaky-integrate-and-fire sweep over the neuron state registers after NACC accumulation. For each neuron index in turn it reads the current membrane value, applies leak and threshold, writes back the new potential, and records a spike bit. It shares the NSR read and write ports with the pipeline. The pipeline always has priority, and the sweeper waits whenever the pipeline is writing.

Parameters:
NUM_NEURONS, 32, number of NSR entries; also the spike vector width
DATA_W, 32, membrane potential width (signed two's complement)
IDX_W, 5, NSR address width (log2 NUM_NEURONS)

Ports:
clk  input  1  clock; all state changes on its rising edge
reset  input  1  synchronous, active-high reset
start  input  1  single-cycle request to begin a sweep; ignored unless in IDLE
num_neurons  input  IDX_W+1  count of neurons to sweep (0..NUM_NEURONS); sampled on accepted start
threshold  input  DATA_W  signed fire threshold; sampled on accepted start
leak_shift  input  5  leak = v >>> leak_shift; 0 disables leak; sampled on accepted start
pipe_nsr_we  input  1  pipeline is writing NSR this cycle (NSRwrite_E | NSRwrite1_W)
pipe_nsr_wa  input  IDX_W  address of that pipeline write
nsr_ra  output  IDX_W  sweeper read address; combinational read
nsr_rd  input  DATA_W  read data for nsr_ra, same cycle
nsr_we  output  1  sweeper write enable
nsr_wa  output  IDX_W  sweeper write address
nsr_wd  output  DATA_W  sweeper write data
busy  output  1  high from the first READ cycle through the DONE cycle
done  output  1  one-cycle pulse in the DONE state
spike_vec  output  NUM_NEURONS  bit i = neuron i fired in the last sweep; held until next accepted start
spike_count  output  IDX_W+1  number of set bits in spike_vec

Behaviour:
- Reset values: state IDLE, idx 0, busy 0, done 0, nsr_we 0, nsr_ra 0, nsr_wa 0, nsr_wd 0, spike_vec 0, spike_count 0. Reset mid-sweep aborts immediately. NSR entries already written stay written.
- States: IDLE, READ, UPDATE, DONE.
- IDLE:
  - On start, latch num_neurons, threshold and leak_shift; clear spike_vec and spike_count; set idx 0.
  - Go to READ, or to DONE if num_neurons == 0.
  - start while not IDLE has no effect.
- READ:
  - nsr_ra = idx.
  - If pipe_nsr_we = 0: latch v = nsr_rd and go to UPDATE.
  - Otherwise stay in READ; no sample is taken.
- UPDATE:
  - Compute vl = v - (v >>> leak_shift), or vl = v when leak_shift == 0.
  - Use a full DATA_W arithmetic shift; the result cannot overflow.
  - fire = (signed vl >= signed threshold).
  - New potential = 0 if fire, else vl.
  - If pipe_nsr_we = 1 and pipe_nsr_wa == idx: the latched v is stale. Go back to READ with the same idx; no write.
  - Else if pipe_nsr_we = 1 (different address): stay in UPDATE; no write.
  - Else drive nsr_we = 1, nsr_wa = idx, nsr_wd = new potential. If fire, set spike_vec[idx] and increment spike_count.
  - After the write, go to DONE if idx == num_neurons-1, else increment idx and go to READ.
- DONE: done = 1 for one cycle, then IDLE.
- nsr_we is never asserted in the same cycle as pipe_nsr_we.
- Uncontended latency:
  - start accepted at cycle t; READ(0) at t+1; UPDATE(0) at t+2.
  - Last write at t+2N; done at t+2N+1; IDLE again at t+2N+2.
  - busy is high from t+1 through t+2N+1.
- num_neurons > NUM_NEURONS is clamped to NUM_NEURONS.

Decomposition:
- Shared package neuro_pkg holds:
  - the state enum (IDLE, READ, UPDATE, DONE);
  - NUM_NEURONS, DATA_W and IDX_W constants;
  - the nsr_idx_t and membrane_t types.
- One sub-module is natural: lif_update. It is a pure combinational function of (v, leak_shift, threshold) producing (new_v, fire), so it can be unit-tested separately.

Test Plan:
- num_neurons=4, threshold=100, leak_shift=0, NSR={150,99,100,-5}, no contention -> writes {0,99,0,-5}; spike_vec=4'b0101, spike_count=2; done at t+9.
- num_neurons=1, leak_shift=2, threshold=60, v=80 -> vl=60, fires, writes 0. With v=76 -> vl=57, no fire, writes 57.
- Contention: pipe_nsr_we=1 to address 7 during READ(2) for 3 cycles -> sweeper holds READ 3 cycles; nsr_we never overlaps; done delayed by 3.
- Stale hazard: pipe_nsr_we=1, wa=2 during UPDATE(2) writing 500 -> sweeper returns to READ(2), rereads 500, fires at threshold 100, writes 0.
- num_neurons=0 -> done at t+1; no nsr_we; spike_vec=0. A second start during busy -> ignored; spike_vec unchanged.
- Reset asserted during UPDATE(1) -> next cycle IDLE; busy=0; spike_vec=0; no further nsr_we.
